// File: rtl/jzjpcc_hazard_pkg.sv
// rtl/jzjpcc_hazard_pkg.sv - shared types for the RV32I hazard sequencer
// Pipeline shadow entries, FSM state and the register-match helper.
package jzjpcc_hazard_pkg;

   typedef logic [4:0]  regaddr_t;
   typedef logic [31:0] word_t;

   typedef struct packed {
      logic     valid;
      regaddr_t rs1;
      regaddr_t rs2;
      logic     uses_rs1;
      logic     uses_rs2;
      regaddr_t rd;
      logic     rd_write;
      logic     is_load;
   } ex_entry_t;

   typedef struct packed {
      logic     valid;
      regaddr_t rd;
      logic     rd_write;
      logic     is_load;
   } mem_entry_t;

   typedef struct packed {
      logic     valid;
      regaddr_t rd;
      logic     rd_write;
   } wb_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

   localparam word_t STALL_COUNT_MAX = 32'hFFFF_FFFF;

   // x0 is hardwired zero, so a write to it never produces a usable value
   function automatic logic writes_reg(input logic valid, input logic rd_write,
                                       input regaddr_t rd, input regaddr_t rs);
      return valid & rd_write & (rd != 5'd0) & (rd == rs);
   endfunction

endpackage

// File: rtl/jzjpcc_hazard_sequencer_if.sv
// rtl/jzjpcc_hazard_sequencer_if.sv - decode/bypass signal bundle for the hazard sequencer
// master drives decode-stage info and stage values; slave is the sequencer.
interface jzjpcc_hazard_sequencer_if;

   logic [4:0]  rs1Addr_decode;
   logic [4:0]  rs2Addr_decode;
   logic        usesRS1_decode;
   logic        usesRS2_decode;
   logic [4:0]  rdAddr_decode;
   logic        rdWrite_decode;
   logic        isLoad_decode;
   logic        flush_execute;
   logic [31:0] aluResult_memory;
   logic [31:0] writebackValue_writeback;

   logic        stall_decode;
   logic        bubble_execute;
   logic        bypassRS1_execute;
   logic        bypassRS2_execute;
   logic [31:0] bypassValueRS1_execute;
   logic [31:0] bypassValueRS2_execute;
   logic [31:0] stallCount;

   modport master (
      output rs1Addr_decode, rs2Addr_decode, usesRS1_decode, usesRS2_decode,
      output rdAddr_decode, rdWrite_decode, isLoad_decode, flush_execute,
      output aluResult_memory, writebackValue_writeback,
      input  stall_decode, bubble_execute, bypassRS1_execute, bypassRS2_execute,
      input  bypassValueRS1_execute, bypassValueRS2_execute, stallCount
   );

   modport slave (
      input  rs1Addr_decode, rs2Addr_decode, usesRS1_decode, usesRS2_decode,
      input  rdAddr_decode, rdWrite_decode, isLoad_decode, flush_execute,
      input  aluResult_memory, writebackValue_writeback,
      output stall_decode, bubble_execute, bypassRS1_execute, bypassRS2_execute,
      output bypassValueRS1_execute, bypassValueRS2_execute, stallCount
   );

endinterface

// File: rtl/jzjpcc_bypass_select.sv
// rtl/jzjpcc_bypass_select.sv - operand forwarding selector for one execute-stage source
// MEM wins over WB; a MEM-stage load blocks forwarding instead of falling back to WB.
module jzjpcc_bypass_select
   import jzjpcc_hazard_pkg::*;
(
   input  logic       ex_valid_i,
   input  logic       uses_i,
   input  regaddr_t   rs_i,
   input  mem_entry_t mem_i,
   input  wb_entry_t  wb_i,
   input  word_t      alu_result_i,
   input  word_t      wb_value_i,
   output logic       bypass_o,
   output word_t      value_o
);

   logic mem_hit;
   logic wb_hit;

   assign mem_hit = writes_reg(mem_i.valid, mem_i.rd_write, mem_i.rd, rs_i);
   assign wb_hit  = writes_reg(wb_i.valid, wb_i.rd_write, wb_i.rd, rs_i);

   always_comb begin
      bypass_o = 1'b0;
      value_o  = '0;
      if (ex_valid_i && uses_i) begin
         if (mem_hit) begin
            if (!mem_i.is_load) begin
               bypass_o = 1'b1;
               value_o  = alu_result_i;
            end
         end else if (wb_hit) begin
            bypass_o = 1'b1;
            value_o  = wb_value_i;
         end
      end
   end

endmodule

// File: rtl/jzjpcc_hazard_sequencer.sv
// rtl/jzjpcc_hazard_sequencer.sv - load-use stall, flush bubble and operand bypass control
// Tracks EX/MEM/WB shadow entries and stalls decode one cycle behind a dependent load.
module jzjpcc_hazard_sequencer
   import jzjpcc_hazard_pkg::*;
(
   input  logic clock,
   input  logic reset,
   jzjpcc_hazard_sequencer_if.slave hz
);

   state_t     state_q, state_d;
   ex_entry_t  ex_q, ex_d;
   mem_entry_t mem_q, mem_d;
   wb_entry_t  wb_q, wb_d;
   word_t      stall_count_q, stall_count_d;

   logic  hazard;
   logic  stall;
   logic  bubble;
   logic  ex_kill;
   logic  byp1, byp2;
   word_t val1, val2;

   assign hazard = ex_q.valid & ex_q.is_load & ex_q.rd_write & (ex_q.rd != 5'd0) &
                   ((hz.usesRS1_decode & (hz.rs1Addr_decode == ex_q.rd)) |
                    (hz.usesRS2_decode & (hz.rs2Addr_decode == ex_q.rd)));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (hazard && !hz.flush_execute) state_d = STALL;
         STALL:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // The stalled load has already moved to MEM by the STALL cycle, so nothing is held twice
   always_comb begin
      stall  = 1'b0;
      bubble = 1'b0;
      if (state_q == RUN) begin
         stall  = hazard & ~hz.flush_execute;
         bubble = hazard | hz.flush_execute;
      end
   end

   assign ex_kill = bubble | hz.flush_execute;

   always_comb begin
      ex_d = '0;
      if (!ex_kill) begin
         ex_d.valid    = 1'b1;
         ex_d.rs1      = hz.rs1Addr_decode;
         ex_d.rs2      = hz.rs2Addr_decode;
         ex_d.uses_rs1 = hz.usesRS1_decode;
         ex_d.uses_rs2 = hz.usesRS2_decode;
         ex_d.rd       = hz.rdAddr_decode;
         ex_d.rd_write = hz.rdWrite_decode;
         ex_d.is_load  = hz.isLoad_decode;
      end
      mem_d.valid    = ex_q.valid;
      mem_d.rd       = ex_q.rd;
      mem_d.rd_write = ex_q.rd_write;
      mem_d.is_load  = ex_q.is_load;
      wb_d.valid     = mem_q.valid;
      wb_d.rd        = mem_q.rd;
      wb_d.rd_write  = mem_q.rd_write;
      stall_count_d  = stall_count_q;
      if (stall && (stall_count_q != STALL_COUNT_MAX)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ex_q          <= '0;
         mem_q         <= '0;
         wb_q          <= '0;
         stall_count_q <= '0;
      end else begin
         ex_q          <= ex_d;
         mem_q         <= mem_d;
         wb_q          <= wb_d;
         stall_count_q <= stall_count_d;
      end
   end

   jzjpcc_bypass_select u_bypass_rs1 (
      .ex_valid_i   (ex_q.valid),
      .uses_i       (ex_q.uses_rs1),
      .rs_i         (ex_q.rs1),
      .mem_i        (mem_q),
      .wb_i         (wb_q),
      .alu_result_i (hz.aluResult_memory),
      .wb_value_i   (hz.writebackValue_writeback),
      .bypass_o     (byp1),
      .value_o      (val1)
   );

   jzjpcc_bypass_select u_bypass_rs2 (
      .ex_valid_i   (ex_q.valid),
      .uses_i       (ex_q.uses_rs2),
      .rs_i         (ex_q.rs2),
      .mem_i        (mem_q),
      .wb_i         (wb_q),
      .alu_result_i (hz.aluResult_memory),
      .wb_value_i   (hz.writebackValue_writeback),
      .bypass_o     (byp2),
      .value_o      (val2)
   );

   assign hz.stall_decode           = stall;
   assign hz.bubble_execute         = bubble;
   assign hz.bypassRS1_execute      = byp1;
   assign hz.bypassRS2_execute      = byp2;
   assign hz.bypassValueRS1_execute = val1;
   assign hz.bypassValueRS2_execute = val2;
   assign hz.stallCount             = stall_count_q;

endmodule

// File: tb/tb_jzjpcc_hazard_sequencer.sv
// tb/tb_jzjpcc_hazard_sequencer.sv - directed bench with an age-ordered pipeline model
// Model: the three in-flight instructions, youngest first; forwarding searches older ones.
module tb_jzjpcc_hazard_sequencer;

   typedef struct packed {
      bit       v;
      bit [4:0] rs1;
      bit [4:0] rs2;
      bit       u1;
      bit       u2;
      bit [4:0] rd;
      bit       w;
      bit       ld;
   } instr_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   jzjpcc_hazard_sequencer_if bus ();

   jzjpcc_hazard_sequencer dut (
      .clock (clock),
      .reset (reset),
      .hz    (bus)
   );

   instr_t    m_age [3];
   bit        m_stalled;
   bit [31:0] m_cnt;
   bit        preload_pulse = 1'b0;
   int        tests = 0;
   int        fails = 0;

   function automatic instr_t decode_now();
      instr_t d;
      d.v   = 1'b1;
      d.rs1 = bus.rs1Addr_decode;
      d.rs2 = bus.rs2Addr_decode;
      d.u1  = bus.usesRS1_decode;
      d.u2  = bus.usesRS2_decode;
      d.rd  = bus.rdAddr_decode;
      d.w   = bus.rdWrite_decode;
      d.ld  = bus.isLoad_decode;
      return d;
   endfunction

   // Decode needs a register that the instruction right ahead of it is still loading
   function automatic bit exp_hazard();
      instr_t p;
      p = m_age[0];
      if (m_stalled || !p.v || !p.ld || !p.w || p.rd == 5'd0) return 1'b0;
      return (bus.usesRS1_decode && bus.rs1Addr_decode == p.rd) ||
             (bus.usesRS2_decode && bus.rs2Addr_decode == p.rd);
   endfunction

   function automatic bit exp_stall();
      return exp_hazard() && !bus.flush_execute;
   endfunction

   function automatic bit exp_bubble();
      return !m_stalled && (exp_hazard() || bus.flush_execute);
   endfunction

   always @(posedge clock or negedge reset or posedge preload_pulse) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) m_age[i] = '0;
         m_stalled = 1'b0;
         m_cnt     = 32'd0;
      end else if (preload_pulse) begin
         m_cnt = 32'hFFFF_FFFE;
      end else begin
         bit st;
         bit kill;
         st   = exp_stall();
         kill = exp_bubble() || bus.flush_execute;
         if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
         m_age[2]  = m_age[1];
         m_age[1]  = m_age[0];
         m_age[0]  = kill ? instr_t'('0) : decode_now();
         m_stalled = st;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_bypass(input bit [4:0] rs, input bit u, output bit b,
                             output bit [31:0] v, output bit bad);
      b   = 1'b0;
      v   = 32'd0;
      bad = 1'b0;
      if (!m_age[0].v || !u || rs == 5'd0) return;
      for (int a = 1; a < 3; a++) begin
         if (m_age[a].v && m_age[a].w && m_age[a].rd == rs) begin
            if (a == 1 && m_age[a].ld) begin
               bad = 1'b1;
               return;
            end
            b = 1'b1;
            v = (a == 1) ? bus.aluResult_memory : bus.writebackValue_writeback;
            return;
         end
      end
   endtask

   task automatic model_check();
      bit b1, b2, bad1, bad2;
      bit [31:0] v1, v2;
      exp_bypass(m_age[0].rs1, m_age[0].u1, b1, v1, bad1);
      exp_bypass(m_age[0].rs2, m_age[0].u2, b2, v2, bad2);
      check("mdl_stall",  bus.stall_decode, exp_stall());
      check("mdl_bubble", bus.bubble_execute, exp_bubble());
      check("mdl_byp1",   bus.bypassRS1_execute, b1);
      check("mdl_val1",   bus.bypassValueRS1_execute, v1);
      check("mdl_byp2",   bus.bypassRS2_execute, b2);
      check("mdl_val2",   bus.bypassValueRS2_execute, v2);
      check("mdl_count",  bus.stallCount, m_cnt);
      check("mdl_load_in_mem_unreachable", {30'd0, bad1, bad2}, 32'd0);
   endtask

   task automatic drv(input bit [4:0] rs1, input bit u1, input bit [4:0] rs2, input bit u2,
                      input bit [4:0] rd, input bit w, input bit ld, input bit fl);
      bus.rs1Addr_decode = rs1;
      bus.usesRS1_decode = u1;
      bus.rs2Addr_decode = rs2;
      bus.usesRS2_decode = u2;
      bus.rdAddr_decode  = rd;
      bus.rdWrite_decode = w;
      bus.isLoad_decode  = ld;
      bus.flush_execute  = fl;
   endtask

   task automatic nop();
      drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic sample();
      @(negedge clock);
      model_check();
   endtask

   task automatic adv();
      @(posedge clock);
      #1;
   endtask

   initial begin
      nop();
      bus.aluResult_memory         = 32'd0;
      bus.writebackValue_writeback = 32'd0;
      reset = 1'b0;
      sample();
      check("rst_count", bus.stallCount, 32'd0);
      check("rst_stall", bus.stall_decode, 32'd0);
      sample();
      #1 reset = 1'b1;
      adv();

      // ALU result forwarded from MEM to both operands
      bus.aluResult_memory = 32'h1234;
      drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0); sample(); adv();
      drv(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); sample(); adv();
      nop(); sample();
      check("alu_byp1", bus.bypassRS1_execute, 32'd1);
      check("alu_val1", bus.bypassValueRS1_execute, 32'h1234);
      check("alu_byp2", bus.bypassRS2_execute, 32'd1);
      check("alu_val2", bus.bypassValueRS2_execute, 32'h1234);
      check("alu_nostall", bus.stall_decode, 32'd0);
      adv();

      // Load-use: one stall cycle, then forward from WB
      bus.writebackValue_writeback = 32'hDEAD_BEEF;
      drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0); sample(); adv();
      drv(5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0); sample();
      check("lu_stall", bus.stall_decode, 32'd1);
      check("lu_bubble", bus.bubble_execute, 32'd1);
      adv();
      sample();
      check("lu_stall_once", bus.stall_decode, 32'd0);
      check("lu_count", bus.stallCount, 32'd1);
      adv();
      nop(); sample();
      check("lu_byp1", bus.bypassRS1_execute, 32'd1);
      check("lu_val1", bus.bypassValueRS1_execute, 32'hDEAD_BEEF);
      check("lu_byp2", bus.bypassRS2_execute, 32'd0);
      adv();

      // x0 writers in MEM and WB are never forwarded
      bus.aluResult_memory         = 32'hAAAA;
      bus.writebackValue_writeback = 32'hBBBB;
      drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); sample(); adv();
      drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); sample(); adv();
      drv(5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); sample(); adv();
      nop(); sample();
      check("x0_byp1", bus.bypassRS1_execute, 32'd0);
      check("x0_val1", bus.bypassValueRS1_execute, 32'd0);
      check("x0_byp2", bus.bypassRS2_execute, 32'd0);
      adv();

      // MEM has priority over WB for the same register
      bus.aluResult_memory         = 32'h1;
      bus.writebackValue_writeback = 32'h2;
      drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); sample(); adv();
      drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); sample(); adv();
      drv(5'd9, 1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); sample(); adv();
      nop(); sample();
      check("prio_val1", bus.bypassValueRS1_execute, 32'h1);
      check("prio_val2", bus.bypassValueRS2_execute, 32'h1);
      adv();

      // WB-only match; rs2 matches too but is not read
      drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0); sample(); adv();
      nop(); sample(); adv();
      drv(5'd10, 1'b1, 5'd10, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); sample(); adv();
      nop(); sample();
      check("wb_val1", bus.bypassValueRS1_execute, 32'h2);
      check("wb_unused_byp2", bus.bypassRS2_execute, 32'd0);
      adv();

      // Flush beats a coincident load-use hazard
      drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0); sample(); adv();
      drv(5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b1); sample();
      check("fl_stall", bus.stall_decode, 32'd0);
      check("fl_bubble", bus.bubble_execute, 32'd1);
      adv();
      nop(); sample();
      check("fl_count", bus.stallCount, 32'd1);
      adv();

      // Asynchronous reset in the middle of a stall
      drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0); sample(); adv();
      drv(5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0); sample();
      check("ar_pre_stall", bus.stall_decode, 32'd1);
      adv();
      #2 reset = 1'b0;
      #1;
      check("ar_count", bus.stallCount, 32'd0);
      check("ar_stall", bus.stall_decode, 32'd0);
      check("ar_bubble", bus.bubble_execute, 32'd0);
      check("ar_byp1", bus.bypassRS1_execute, 32'd0);
      sample();
      #1 reset = 1'b1;
      adv();
      sample();
      check("ar_fresh_nostall", bus.stall_decode, 32'd0);
      adv();

      // Saturation from a preloaded counter
      preload_pulse = 1'b1;
      force dut.stall_count_q = 32'hFFFF_FFFE;
      #1 release dut.stall_count_q;
      preload_pulse = 1'b0;
      drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0); sample();
      check("sat_preload", bus.stallCount, 32'hFFFF_FFFE);
      adv();
      drv(5'd14, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0); sample();
      check("sat_stall1", bus.stall_decode, 32'd1);
      adv();
      sample();
      check("sat_count1", bus.stallCount, 32'hFFFF_FFFF);
      adv();
      drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0); sample(); adv();
      drv(5'd15, 1'b0, 5'd15, 1'b1, 5'd17, 1'b1, 1'b0, 1'b0); sample();
      check("sat_stall2", bus.stall_decode, 32'd1);
      adv();
      sample();
      check("sat_count2", bus.stallCount, 32'hFFFF_FFFF);
      adv();

      nop();
      for (int i = 0; i < 3; i++) begin
         sample();
         adv();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/jzjpcc_hazard_sequencer.md
JZJPCC_HAZARD_SEQUENCER -- requirements
Module: jzjpcc_hazard_sequencer

Interface
REQ-001 Parameters SHALL be: none; all widths fixed (RV32I, 5-bit register addresses, 32-bit data).
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserting it (0) SHALL clear all state immediately, independent of clock.
REQ-004 rs1Addr_decode, rs2Addr_decode  input  5 each  source registers of the instruction in decode.
REQ-005 usesRS1_decode, usesRS2_decode  input  1 each  decode instruction reads rs1/rs2.
REQ-006 rdAddr_decode  input  5  destination register; rdWrite_decode  input  1  writes rd; isLoad_decode  input  1  instruction is a load.
REQ-007 flush_execute  input  1  taken branch/jump resolved in execute; decode and fetch contents are wrong-path.
REQ-008 aluResult_memory  input  32  result currently in memory stage; writebackValue_writeback  input  32  value being written back.
REQ-009 stall_decode  output  1  hold fetch PC and decode register this cycle.
REQ-010 bubble_execute  output  1  execute register loads a NOP next edge.
REQ-011 bypassRS1_execute, bypassRS2_execute  output  1 each  select bypass value in the ALU operand mux.
REQ-012 bypassValueRS1_execute, bypassValueRS2_execute  output  32 each  forwarded operand values.
REQ-013 stallCount  output  32  saturating count of load-use stall cycles.

Function
REQ-014 Block SHALL keep shadow entries: EX {valid, rs1, rs2, usesRS1, usesRS2, rd, rdWrite, isLoad}, MEM {valid, rd, rdWrite, isLoad}, WB {valid, rd, rdWrite}.
REQ-015 Each edge without stall/flush: EX <= decode inputs (valid=1), MEM <= EX, WB <= MEM.
REQ-016 Load-use hazard SHALL be: EX.valid & EX.isLoad & EX.rdWrite & EX.rd!=0 & ((usesRS1_decode & rs1Addr_decode==EX.rd) | (usesRS2_decode & rs2Addr_decode==EX.rd)).
REQ-017 FSM states RUN, STALL; RUN->STALL on hazard & !flush_execute; STALL->RUN unconditionally after exactly one cycle; STALL->RUN also on flush.
REQ-018 stall_decode and bubble_execute SHALL be combinational, asserted in the same cycle the hazard is detected in RUN; never asserted in STALL state.
REQ-019 On stall: EX <= bubble (valid=0), MEM and WB advance normally.
REQ-020 flush_execute SHALL win over stall: stall_decode=0, bubble_execute=1, EX <= bubble; MEM/WB advance (flushing instruction proceeds).
REQ-021 Bypass per operand (combinational from EX entry): MEM match (valid, rdWrite, rd!=0, rd==EX.rsX, !isLoad) -> aluResult_memory; else WB match (valid, rdWrite, rd!=0) -> writebackValue_writeback; else bypass=0, value=32'h0.
REQ-022 MEM priority over WB when both match; register x0 SHALL never be bypassed.
REQ-023 A MEM-stage load matching EX.rsX SHALL NOT be bypassed and SHALL NOT fall through to WB; unreachable when REQ-016..019 hold (bench asserts).
REQ-024 Bypass outputs SHALL be 0 when EX.valid=0 or usesRSx=0.
REQ-025 stallCount SHALL increment by 1 per cycle stall_decode=1, saturating at 32'hFFFFFFFF.

Reset
REQ-026 While reset=0: state=RUN, EX/MEM/WB valid=0, stallCount=0; hence stall_decode=0, bubble_execute=0, all bypass selects/values 0.
REQ-027 Reset asserted mid-stall SHALL abort the stall; first post-reset edge treats decode as fresh.

Structure
REQ-028 Package jzjpcc_hazard_pkg SHALL hold regaddr_t (5-bit), ex_entry_t/mem_entry_t/wb_entry_t structs, state_t enum {RUN, STALL}.
REQ-029 Sub-module jzjpcc_bypass_select SHALL implement REQ-021..024 for one operand, instantiated twice.

Verification
REQ-030 ADD x5 then ADD x6,x5,x5 back-to-back, aluResult_memory=32'h1234 -> both bypass=1, values 32'h1234, no stall.
REQ-031 LW x7 then ADD x8,x7,x1 -> stall_decode=1 for exactly one cycle, stallCount=1; next cycle bypassRS1=1 value=writebackValue_writeback (32'hDEAD_BEEF), bypassRS2=0.
REQ-032 Writes to x0 in MEM and WB, consumer reads x0 -> bypass=0, value 0.
REQ-033 x9 written in both MEM (32'h1) and WB (32'h2), consumer reads x9 -> value 32'h1.
REQ-034 Load-use hazard coincident with flush_execute=1 -> stall_decode=0, bubble_execute=1, state stays RUN, stallCount unchanged.
REQ-035 reset pulsed low during STALL -> outputs 0 asynchronously; preload stallCount 32'hFFFFFFFF then stall -> stays 32'hFFFFFFFF.
